// File: rtl/video_pkg.sv
// Shared types for the DVP video pipeline stages: FSM states and crop/mask mode selectors.
package video_pkg;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  localparam int MODE_CROP = 32'sd0;
  localparam int MODE_MASK = 32'sd1;

endpackage

// File: rtl/video_pos_counter.sv
// Pixel position tracker driven only by DE/VS: frame-start detect and saturating x/y counters.
// o_x/o_y give the position of the pixel presented this cycle (frame start forces 0,0).
module video_pos_counter
  import video_pkg::*;
#(
  parameter int   X_W    = 12,
  parameter int   Y_W    = 12,
  parameter logic VS_POL = 1'b1
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_vs,
  input  logic           i_de,
  output logic           o_fs,
  output logic [X_W-1:0] o_x,
  output logic [Y_W-1:0] o_y
);

  logic           r_vs_act;
  logic           r_de;
  logic [X_W-1:0] r_x;
  logic [Y_W-1:0] r_y;
  logic           w_vs_act;
  logic           w_fs;

  assign w_vs_act = (i_vs == VS_POL);
  assign w_fs     = w_vs_act & ~r_vs_act;
  assign o_fs     = w_fs;
  assign o_x      = w_fs ? {X_W{1'b0}} : r_x;
  assign o_y      = w_fs ? {Y_W{1'b0}} : r_y;

  // Edge history and counters; a pixel on the frame-start clock is x=0, so next one is x=1.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vs_act <= 1'b0;
      r_de     <= 1'b0;
      r_x      <= {X_W{1'b0}};
      r_y      <= {Y_W{1'b0}};
    end else begin
      r_vs_act <= w_vs_act;
      r_de     <= i_de;
      if (w_fs) begin
        r_x <= i_de ? {{(X_W-1){1'b0}}, 1'b1} : {X_W{1'b0}};
        r_y <= {Y_W{1'b0}};
      end else if (i_de) begin
        if (!(&r_x)) r_x <= r_x + {{(X_W-1){1'b0}}, 1'b1};
      end else if (r_de) begin
        r_x <= {X_W{1'b0}};
        if (!(&r_y)) r_y <= r_y + {{(Y_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: rtl/video_window_crop.sv
// Crop/mask stage: gates or fills pixels outside a per-frame shadowed rectangle, 1-clk registered.
module video_window_crop
  import video_pkg::*;
#(
  parameter int                DATA_W = 24,
  parameter int                X_W    = 12,
  parameter int                Y_W    = 12,
  parameter int                MODE   = MODE_CROP,
  parameter logic [DATA_W-1:0] FILL   = {DATA_W{1'b0}},
  parameter logic              VS_POL = 1'b1,
  parameter logic              HS_POL = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [X_W-1:0]    i_start_x,
  input  logic [Y_W-1:0]    i_start_y,
  input  logic [X_W-1:0]    i_end_x,
  input  logic [Y_W-1:0]    i_end_y,
  input  logic              i_hs,
  input  logic              i_vs,
  input  logic              i_de,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_hs,
  output logic              o_vs,
  output logic              o_de,
  output logic [DATA_W-1:0] o_data,
  output logic              o_locked,
  output logic              o_win_err
);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [X_W-1:0]    r_sx, r_ex;
  logic [Y_W-1:0]    r_sy, r_ey;
  logic              r_win_err;
  logic              r_locked;
  logic              r_hs, r_vs, r_de;
  logic [DATA_W-1:0] r_data;

  logic              w_fs;
  logic [X_W-1:0]    w_x, w_sx, w_ex;
  logic [Y_W-1:0]    w_y, w_sy, w_ey;
  logic              w_cfg_err, w_err, w_inside, w_active;
  logic              w_de_nxt;
  logic [DATA_W-1:0] w_data_nxt;

  video_pos_counter #(
    .X_W    (X_W),
    .Y_W    (Y_W),
    .VS_POL (VS_POL)
  ) u_pos (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_vs    (i_vs),
    .i_de    (i_de),
    .o_fs    (w_fs),
    .o_x     (w_x),
    .o_y     (w_y)
  );

  // On the frame-start clock the incoming config is already the one in force.
  assign w_sx      = w_fs ? i_start_x : r_sx;
  assign w_ex      = w_fs ? i_end_x   : r_ex;
  assign w_sy      = w_fs ? i_start_y : r_sy;
  assign w_ey      = w_fs ? i_end_y   : r_ey;
  assign w_cfg_err = (i_start_x >= i_end_x) | (i_start_y >= i_end_y);
  assign w_err     = w_fs ? w_cfg_err : r_win_err;
  assign w_inside  = (w_x >= w_sx) & (w_x < w_ex) & (w_y >= w_sy) & (w_y < w_ey) & ~w_err;
  assign w_active  = (r_state == ST_ACTIVE) | w_fs;

  // Next-state logic: lock onto the first frame start and stay until reset.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_fs) w_state_nxt = ST_ACTIVE;
        else      w_state_nxt = ST_IDLE;
      end
      ST_ACTIVE: w_state_nxt = ST_ACTIVE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Output pixel selection for crop or mask behaviour.
  always_comb begin
    w_de_nxt   = 1'b0;
    w_data_nxt = {DATA_W{1'b0}};
    if (w_active) begin
      if (MODE == MODE_MASK) begin
        w_de_nxt   = i_de;
        w_data_nxt = w_inside ? i_data : FILL;
      end else begin
        w_de_nxt   = i_de & w_inside;
        w_data_nxt = w_inside ? i_data : {DATA_W{1'b0}};
      end
    end else begin
      w_de_nxt   = 1'b0;
      w_data_nxt = {DATA_W{1'b0}};
    end
  end

  // State, per-frame shadow config and the aligned output register stage.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_sx      <= {X_W{1'b0}};
      r_ex      <= {X_W{1'b0}};
      r_sy      <= {Y_W{1'b0}};
      r_ey      <= {Y_W{1'b0}};
      r_win_err <= 1'b0;
      r_locked  <= 1'b0;
      r_hs      <= ~HS_POL;
      r_vs      <= ~VS_POL;
      r_de      <= 1'b0;
      r_data    <= {DATA_W{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      if (w_fs) begin
        r_sx      <= i_start_x;
        r_ex      <= i_end_x;
        r_sy      <= i_start_y;
        r_ey      <= i_end_y;
        r_win_err <= w_cfg_err;
        r_locked  <= 1'b1;
      end
      r_hs   <= i_hs;
      r_vs   <= i_vs;
      r_de   <= w_de_nxt;
      r_data <= w_data_nxt;
    end
  end

  assign o_hs      = r_hs;
  assign o_vs      = r_vs;
  assign o_de      = r_de;
  assign o_data    = r_data;
  assign o_locked  = r_locked;
  assign o_win_err = r_win_err;

endmodule

// File: tb/tb_video_window_crop.sv
// Directed bench: crop and mask instances share stimulus; per-pixel and per-frame expectations.
module tb_video_window_crop;

  localparam logic [23:0] FILL_M = 24'h0000FF;
  localparam int FW = 8;
  localparam int FH = 6;

  logic        clk, rst_n;
  logic [11:0] start_x, start_y, end_x, end_y;
  logic        hs, vs, de;
  logic [23:0] data;
  logic        hs_c, vs_c, de_c, locked_c, err_c;
  logic [23:0] data_c;
  logic        hs_m, vs_m, de_m, locked_m, err_m;
  logic [23:0] data_m;

  int n_pass, n_total;
  int crop_cnt, mask_pass, mask_fill;
  bit m_locked;

  video_window_crop #(.MODE(0)) u_crop (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_start_x(start_x), .i_start_y(start_y), .i_end_x(end_x), .i_end_y(end_y),
    .i_hs(hs), .i_vs(vs), .i_de(de), .i_data(data),
    .o_hs(hs_c), .o_vs(vs_c), .o_de(de_c), .o_data(data_c),
    .o_locked(locked_c), .o_win_err(err_c)
  );

  video_window_crop #(.MODE(1), .FILL(FILL_M)) u_mask (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_start_x(start_x), .i_start_y(start_y), .i_end_x(end_x), .i_end_y(end_y),
    .i_hs(hs), .i_vs(vs), .i_de(de), .i_data(data),
    .o_hs(hs_m), .o_vs(vs_m), .o_de(de_m), .o_data(data_m),
    .o_locked(locked_m), .o_win_err(err_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [23:0] pix(input int y, input int x);
    logic [3:0] yy, xx;
    yy = y[3:0];
    xx = x[3:0];
    return {8'hC0, yy, xx, 8'h3C};
  endfunction

  // One pixel clock: drive, let the edge capture it, then compare the registered outputs.
  task automatic step(input logic h, input logic v, input logic d_en, input logic [23:0] d,
                      input bit ins);
    @(negedge clk);
    hs = h; vs = v; de = d_en; data = d;
    @(posedge clk);
    #1;
    check("hs_dly", {31'd0, hs_c}, {31'd0, h});
    check("vs_dly", {31'd0, vs_c}, {31'd0, v});
    check("de_crop", {31'd0, de_c}, {31'd0, m_locked & d_en & ins});
    check("de_mask", {31'd0, de_m}, {31'd0, m_locked & d_en});
    if (m_locked && d_en) begin
      check("data_crop", {8'd0, data_c}, {8'd0, ins ? d : 24'h000000});
      check("data_mask", {8'd0, data_m}, {8'd0, ins ? d : FILL_M});
    end
    if (de_c) crop_cnt++;
    if (de_m && data_m !== FILL_M) mask_pass++;
    if (de_m && data_m === FILL_M) mask_fill++;
  endtask

  // One 8x6 frame; model keeps the config in force at frame start even if inputs change.
  task automatic run_frame(input logic [11:0] sx, input logic [11:0] sy,
                           input logic [11:0] ex, input logic [11:0] ey, input int chg_line,
                           input logic [11:0] nsx, input logic [11:0] nsy,
                           input logic [11:0] nex, input logic [11:0] ney);
    bit err, ins;
    err = (sx >= ex) || (sy >= ey);
    start_x = sx; start_y = sy; end_x = ex; end_y = ey;
    crop_cnt = 0; mask_pass = 0; mask_fill = 0;
    m_locked = 1'b1;
    step(1'b0, 1'b1, 1'b0, 24'h0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 24'h0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 24'h0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 24'h0, 1'b0);
    for (int y = 0; y < FH; y++) begin
      if (y == chg_line) begin
        start_x = nsx; start_y = nsy; end_x = nex; end_y = ney;
      end
      for (int x = 0; x < FW; x++) begin
        ins = (x >= int'(sx)) && (x < int'(ex)) && (y >= int'(sy)) && (y < int'(ey)) && !err;
        step(1'b0, 1'b0, 1'b1, pix(y, x), ins);
      end
      step(1'b1, 1'b0, 1'b0, 24'h0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 24'h0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 24'h0, 1'b0);
    end
    check("win_err", {31'd0, err_c}, {31'd0, err});
  endtask

  typedef struct {
    logic [11:0] sx, sy, ex, ey;
    int          exp_crop;
    logic        exp_err;
  } vec_t;

  vec_t tbl[6];

  initial begin
    n_pass = 0; n_total = 0; m_locked = 1'b0;
    crop_cnt = 0; mask_pass = 0; mask_fill = 0;
    tbl[0] = '{12'd2,  12'd1,  12'd5,  12'd3,  6,  1'b0};
    tbl[1] = '{12'd0,  12'd0,  12'd8,  12'd6,  48, 1'b0};
    tbl[2] = '{12'd5,  12'd0,  12'd5,  12'd6,  0,  1'b1};
    tbl[3] = '{12'd10, 12'd10, 12'd20, 12'd20, 0,  1'b0};
    tbl[4] = '{12'd6,  12'd4,  12'd12, 12'd9,  4,  1'b0};
    tbl[5] = '{12'd3,  12'd2,  12'd1,  12'd5,  0,  1'b1};

    rst_n = 1'b1; hs = 1'b0; vs = 1'b0; de = 1'b0; data = 24'h0;
    start_x = 12'd0; start_y = 12'd0; end_x = 12'd0; end_y = 12'd0;
    #3 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_de", {31'd0, de_c}, 32'd0);
    check("rst_data", {8'd0, data_c}, 32'd0);
    check("rst_hs", {31'd0, hs_c}, 32'd0);
    check("rst_vs", {31'd0, vs_c}, 32'd0);
    check("rst_locked", {31'd0, locked_c}, 32'd0);
    check("rst_err", {31'd0, err_c}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int l = 0; l < 3; l++) begin
      for (int x = 0; x < FW; x++) step(1'b0, 1'b0, 1'b1, pix(l, x), 1'b1);
      step(1'b1, 1'b0, 1'b0, 24'h0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 24'h0, 1'b0);
    end
    check("novs_locked", {31'd0, locked_c}, 32'd0);
    check("novs_cnt", crop_cnt + mask_pass + mask_fill, 32'd0);

    for (int i = 0; i < 6; i++) begin
      run_frame(tbl[i].sx, tbl[i].sy, tbl[i].ex, tbl[i].ey, -1,
                12'd0, 12'd0, 12'd0, 12'd0);
      check("tbl_crop_cnt", crop_cnt, tbl[i].exp_crop);
      check("tbl_mask_pass", mask_pass, tbl[i].exp_crop);
      check("tbl_mask_fill", mask_fill, 48 - tbl[i].exp_crop);
      check("tbl_err", {31'd0, err_m}, {31'd0, tbl[i].exp_err});
      check("tbl_locked", {31'd0, locked_c}, 32'd1);
    end

    run_frame(12'd2, 12'd1, 12'd5, 12'd3, 3, 12'd0, 12'd0, 12'd8, 12'd6);
    check("chg_cur_cnt", crop_cnt, 32'd6);
    run_frame(12'd0, 12'd0, 12'd8, 12'd6, -1, 12'd0, 12'd0, 12'd0, 12'd0);
    check("chg_next_cnt", crop_cnt, 32'd48);

    start_x = 12'd0; start_y = 12'd0; end_x = 12'd1; end_y = 12'd1;
    crop_cnt = 0;
    step(1'b0, 1'b0, 1'b0, 24'h0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 24'h123456, 1'b1);
    step(1'b0, 1'b1, 1'b1, 24'h654321, 1'b0);
    step(1'b0, 1'b0, 1'b0, 24'h0, 1'b0);
    check("fs_de_cnt", crop_cnt, 32'd1);

    start_x = 12'd0; start_y = 12'd0; end_x = 12'd8; end_y = 12'd6;
    step(1'b0, 1'b1, 1'b0, 24'h0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 24'h0, 1'b0);
    for (int x = 0; x < 4; x++) step(1'b0, 1'b0, 1'b1, pix(0, x), 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_de", {31'd0, de_c}, 32'd0);
    check("mid_rst_data", {8'd0, data_m}, 32'd0);
    check("mid_rst_vs", {31'd0, vs_m}, 32'd0);
    check("mid_rst_locked", {31'd0, locked_m}, 32'd0);
    check("mid_rst_de_m", {31'd0, de_m}, 32'd0);
    m_locked = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    crop_cnt = 0; mask_pass = 0; mask_fill = 0;
    for (int x = 4; x < FW; x++) step(1'b0, 1'b0, 1'b1, pix(0, x), 1'b1);
    step(1'b1, 1'b0, 1'b0, 24'h0, 1'b0);
    for (int x = 0; x < FW; x++) step(1'b0, 1'b0, 1'b1, pix(1, x), 1'b1);
    step(1'b0, 1'b0, 1'b0, 24'h0, 1'b0);
    check("post_rst_cnt", crop_cnt + mask_pass + mask_fill, 32'd0);
    check("post_rst_locked", {31'd0, locked_c}, 32'd0);
    run_frame(12'd0, 12'd0, 12'd8, 12'd6, -1, 12'd0, 12'd0, 12'd0, 12'd0);
    check("resume_cnt", crop_cnt, 32'd48);
    check("resume_locked", {31'd0, locked_c}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
